// File: rtl/alarm_ring_ctrl.sv
// Multi-alarm ring controller.
// Compares the live time against N_ALARMS programmable alarm times. A rising match edge
// starts a ring event on the lowest-index triggering channel. The event supports a bounded
// number of snoozes and ends on dismiss (disarm) or after RING_MAX_MIN minutes of ringing.
// Optional build macro BEEP_PATTERN_EN: while ringing, z toggles on every sec_tick.
module alarm_ring_ctrl #(
    parameter int unsigned N_ALARMS     = 2,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DIGIT_W      = 6,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned MAX_SNOOZE   = 3,
    parameter int unsigned RING_MAX_MIN = 10,
    localparam int unsigned TIME_W      = DIGITS * DIGIT_W,
    localparam int unsigned SL_W        = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIME_W-1:0]            time_digits,
    input  logic [N_ALARMS*TIME_W-1:0]   alarm_digits,
    input  logic [N_ALARMS-1:0]          alarm_en,
    input  logic                         snooze,
    input  logic                         min_tick,
    input  logic                         sec_tick,
    output logic                         z,
    output logic [N_ALARMS-1:0]          ringing,
    output logic                         snoozed,
    output logic [SL_W-1:0]              snooze_left
);

    localparam int unsigned RING_W = $clog2(RING_MAX_MIN + 1);
    localparam int unsigned SNZ_W  = $clog2(SNOOZE_MIN + 1);

    localparam logic [SL_W-1:0]   SL_MAX    = SL_W'(MAX_SNOOZE);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MAX_MIN - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

    typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;

    state_e              state_q;
    logic [RING_W-1:0]   ring_cnt_q;
    logic [SNZ_W-1:0]    snz_cnt_q;
    logic [N_ALARMS-1:0] match;
    logic [N_ALARMS-1:0] match_q;
    logic [N_ALARMS-1:0] pend_q;
    logic [N_ALARMS-1:0] trig;
    logic [N_ALARMS-1:0] cand;
    logic [N_ALARMS-1:0] first_hot;
    logic                primed_q;
    logic                dismiss;
    logic                can_snooze;
    logic                ring_timeout;

    // Per-channel compare: every digit equal and the channel armed.
    always_comb begin
        match = '0;
        for (int k = 0; k < N_ALARMS; k++) begin
            match[k] = alarm_en[k] && (alarm_digits[k*TIME_W +: TIME_W] == time_digits);
        end
    end

    // Edges only count once history has been sampled after reset, so a match that was
    // already standing across reset is not mistaken for a new alarm event.
    assign trig = primed_q ? (match & ~match_q) : '0;

    // In IDLE an edge that arrived on the cycle of the return to IDLE is still honoured
    // while its channel keeps matching.
    assign cand         = (state_q == StIdle) ? (trig | (pend_q & match)) : trig;
    assign first_hot    = cand & (~cand + N_ALARMS'(1));
    assign dismiss      = |(ringing & ~alarm_en);
    assign can_snooze   = (snooze_left != '0);
    assign ring_timeout = min_tick && (ring_cnt_q >= RING_LAST);

    // Match history register for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q  <= '0;
            primed_q <= 1'b0;
        end else begin
            match_q  <= match;
            primed_q <= 1'b1;
        end
    end

    // Ring FSM with registered outputs and minute counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            z           <= 1'b0;
            ringing     <= '0;
            snoozed     <= 1'b0;
            snooze_left <= SL_MAX;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            pend_q      <= '0;
        end else begin
            pend_q <= '0;
            case (state_q)
                StIdle: begin
                    if (|cand) begin
                        state_q     <= StRinging;
                        ringing     <= first_hot;
                        snooze_left <= SL_MAX;
                        ring_cnt_q  <= '0;
                        z           <= 1'b1;
                    end
                end
                StRinging: begin
                    if (dismiss || ring_timeout) begin
                        state_q    <= StIdle;
                        z          <= 1'b0;
                        ringing    <= '0;
                        ring_cnt_q <= '0;
                        pend_q     <= trig;
                    end else if (snooze && can_snooze) begin
                        state_q     <= StSnoozed;
                        snooze_left <= snooze_left - SL_W'(1);
                        snz_cnt_q   <= SNZ_LOAD;
                        snoozed     <= 1'b1;
                        z           <= 1'b0;
                    end else begin
                        if (min_tick && (ring_cnt_q < RING_LAST)) begin
                            ring_cnt_q <= ring_cnt_q + RING_W'(1);
                        end
`ifdef BEEP_PATTERN_EN
                        if (sec_tick) begin
                            z <= ~z;
                        end
`endif
                    end
                end
                StSnoozed: begin
                    if (dismiss) begin
                        state_q   <= StIdle;
                        z         <= 1'b0;
                        ringing   <= '0;
                        snoozed   <= 1'b0;
                        snz_cnt_q <= '0;
                        pend_q    <= trig;
                    end else if (|trig) begin
                        // A new alarm preempts the snoozed one with a fresh snooze budget.
                        state_q     <= StRinging;
                        ringing     <= first_hot;
                        snooze_left <= SL_MAX;
                        ring_cnt_q  <= '0;
                        snz_cnt_q   <= '0;
                        snoozed     <= 1'b0;
                        z           <= 1'b1;
                    end else if (min_tick) begin
                        if (snz_cnt_q <= SNZ_ONE) begin
                            state_q    <= StRinging;
                            ring_cnt_q <= '0;
                            snz_cnt_q  <= '0;
                            snoozed    <= 1'b0;
                            z          <= 1'b1;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - SNZ_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    z       <= 1'b0;
                    ringing <= '0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

`ifndef BEEP_PATTERN_EN
    logic unused_sec_tick;
    assign unused_sec_tick = sec_tick;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed scenarios followed by random stimulus,
// expected outputs from a behavioural model pushed to a scoreboard queue and checked by an
// independent monitor one time unit after each rising clock edge.
module tb_alarm_ring_ctrl;

    localparam int N    = 2;
    localparam int TW   = 24;
    localparam int SMIN = 5;
    localparam int SMAX = 3;
    localparam int RMAX = 10;
    localparam int SLW  = 2;

    localparam int MIdle = 0;
    localparam int MRing = 1;
    localparam int MSnz  = 2;

    typedef struct packed {
        logic           z;
        logic [N-1:0]   ring;
        logic           snz;
        logic [SLW-1:0] left;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [TW-1:0]     time_digits = '0;
    logic [N*TW-1:0]   alarm_digits = '0;
    logic [N-1:0]      alarm_en = '0;
    logic              snooze = 1'b0;
    logic              min_tick = 1'b0;
    logic              sec_tick = 1'b0;
    logic              z;
    logic [N-1:0]      ringing;
    logic              snoozed;
    logic [SLW-1:0]    snooze_left;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state
    int           m_mode;
    int           m_ch;
    int           m_left;
    int           m_mins;
    int           m_snz;
    bit           m_z;
    bit [N-1:0]   m_prev;
    bit [N-1:0]   m_pend;
    bit           m_primed;

    alarm_ring_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .time_digits  (time_digits),
        .alarm_digits (alarm_digits),
        .alarm_en     (alarm_en),
        .snooze       (snooze),
        .min_tick     (min_tick),
        .sec_tick     (sec_tick),
        .z            (z),
        .ringing      (ringing),
        .snoozed      (snoozed),
        .snooze_left  (snooze_left)
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] hhmm(int h, int m);
        return {6'(h / 10), 6'(h % 10), 6'(m / 10), 6'(m % 10)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MIdle;
        m_ch     = 0;
        m_left   = SMAX;
        m_mins   = 0;
        m_snz    = 0;
        m_z      = 1'b0;
        m_prev   = '0;
        m_pend   = '0;
        m_primed = 1'b0;
    endtask

    task automatic start_ring(int ch);
        m_mode = MRing;
        m_ch   = ch;
        m_left = SMAX;
        m_mins = 0;
        m_z    = 1'b1;
    endtask

    // One rising clock edge of the specified behaviour, using the inputs now applied.
    task automatic model_step(output exp_t e);
        bit [N-1:0] mt;
        bit [N-1:0] edges;
        bit [N-1:0] cand;
        int fe;
        int fc;
        for (int k = 0; k < N; k++) begin
            mt[k] = alarm_en[k] && (alarm_digits[k*TW +: TW] == time_digits);
        end
        edges = m_primed ? (mt & ~m_prev) : '0;
        cand  = edges | (m_pend & mt);
        fe = -1;
        fc = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (edges[k]) fe = k;
            if (cand[k]) fc = k;
        end
        m_pend = '0;
        if (m_mode == MIdle) begin
            if (fc >= 0) start_ring(fc);
        end else if (m_mode == MRing) begin
            if (!alarm_en[m_ch] || (min_tick && (m_mins + 1 >= RMAX))) begin
                m_mode = MIdle;
                m_z    = 1'b0;
                m_pend = edges;
            end else if (snooze && m_left > 0) begin
                m_mode = MSnz;
                m_left = m_left - 1;
                m_snz  = SMIN;
                m_z    = 1'b0;
            end else begin
                if (min_tick) m_mins = m_mins + 1;
`ifdef BEEP_PATTERN_EN
                if (sec_tick) m_z = !m_z;
`endif
            end
        end else begin
            if (!alarm_en[m_ch]) begin
                m_mode = MIdle;
                m_z    = 1'b0;
                m_pend = edges;
            end else if (fe >= 0) begin
                start_ring(fe);
            end else if (min_tick) begin
                m_snz = m_snz - 1;
                if (m_snz == 0) begin
                    m_mode = MRing;
                    m_mins = 0;
                    m_z    = 1'b1;
                end
            end
        end
        m_prev   = mt;
        m_primed = 1'b1;
        e.z    = m_z;
        e.ring = '0;
        if (m_mode != MIdle) e.ring[m_ch] = 1'b1;
        e.snz  = (m_mode == MSnz);
        e.left = SLW'(m_left);
    endtask

    // Called at a falling edge with inputs set; advances one full clock.
    task automatic tick();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clk);
        snooze   = 1'b0;
        min_tick = 1'b0;
        sec_tick = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic pulse_min(int n);
        repeat (n) begin
            min_tick = 1'b1;
            tick();
            tick();
        end
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_z"}, 32'(z), 32'(0));
        chk({tag, "_ringing"}, 32'(ringing), 32'(0));
        chk({tag, "_snoozed"}, 32'(snoozed), 32'(0));
        chk({tag, "_snooze_left"}, 32'(snooze_left), 32'(SMAX));
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("z", 32'(z), 32'(e.z));
            chk("ringing", 32'(ringing), 32'(e.ring));
            chk("snoozed", 32'(snoozed), 32'(e.snz));
            chk("snooze_left", 32'(snooze_left), 32'(e.left));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [TW-1:0] pick_time(int sel);
        case (sel)
            0:       return hhmm(7, 30);
            1:       return hhmm(6, 0);
            2:       return hhmm(12, 0);
            default: return hhmm(6, 1);
        endcase
    endfunction

    initial begin : driver
        alarm_digits = {hhmm(6, 0), hhmm(7, 30)};
        alarm_en     = 2'b01;
        time_digits  = hhmm(0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        // Basic ring, no retrigger while matching, timeout after RMAX minutes
        idle(3);
        time_digits = hhmm(7, 30);
        idle(2);
        pulse_min(3);
        sec_tick = 1'b1;
        tick();
        pulse_min(7);
        idle(2);

        // Snooze cycle until the snooze budget is exhausted
        time_digits = hhmm(0, 0);
        idle(1);
        time_digits = hhmm(7, 30);
        idle(2);
        repeat (3) begin
            snooze = 1'b1;
            tick();
            idle(1);
            pulse_min(SMIN);
        end
        snooze = 1'b1;
        tick();
        idle(2);
        repeat (4) begin
            sec_tick = 1'b1;
            tick();
            tick();
        end

        // Dismiss while ringing, while snoozed, and together with snooze
        alarm_en = 2'b00;
        idle(2);
        alarm_en = 2'b01;
        idle(2);
        snooze = 1'b1;
        tick();
        idle(1);
        alarm_en = 2'b00;
        idle(2);
        alarm_en = 2'b01;
        idle(2);
        snooze   = 1'b1;
        alarm_en = 2'b00;
        tick();
        idle(2);

        // Simultaneous match and preemption while snoozed
        alarm_digits = {hhmm(6, 0), hhmm(6, 0)};
        alarm_en     = 2'b11;
        time_digits  = hhmm(5, 59);
        idle(1);
        time_digits = hhmm(6, 0);
        idle(2);
        alarm_en = 2'b00;
        idle(1);
        alarm_en = 2'b01;
        idle(2);
        snooze = 1'b1;
        tick();
        idle(1);
        alarm_en = 2'b11;
        idle(3);

        // Asynchronous reset mid-ring, standing match must not retrigger
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(5);
        time_digits = hhmm(6, 1);
        idle(1);
        time_digits = hhmm(6, 0);
        idle(3);

        // Random traffic
        alarm_digits = {hhmm(6, 0), hhmm(7, 30)};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) time_digits = pick_time(int'($urandom_range(3)));
            if ($urandom_range(49) == 0) alarm_en = N'($urandom_range(3));
            if ($urandom_range(399) == 0) begin
                alarm_digits = {pick_time(int'($urandom_range(3))),
                                pick_time(int'($urandom_range(3)))};
            end
            snooze   = ($urandom_range(9) == 0);
            min_tick = ($urandom_range(5) == 0);
            sec_tick = ($urandom_range(3) == 0);
            tick();
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
Multi-alarm ring controller. It compares the live clock-time digits against N programmable alarm times and drives the buzzer enable. It adds what a single-alarm match latch lacks: rising-edge match detection, snooze with a bounded repeat count, and automatic ring timeout. It sits between the timekeeping counters/alarm-setting registers and the buzzer/LED output stage.

Parameters:
N_ALARMS, 2, number of independent alarm channels (1..8)
DIGITS, 4, time digits compared per alarm
DIGIT_W, 6, bits per digit
SNOOZE_MIN, 5, snooze length in min_tick pulses (>=1)
MAX_SNOOZE, 3, snoozes allowed per ring event (0 = snooze disabled)
RING_MAX_MIN, 10, ring timeout in min_tick pulses (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
time_digits  in  DIGITS*DIGIT_W  current time; digit 0 in the LSBs
alarm_digits  in  N_ALARMS*DIGITS*DIGIT_W  alarm times; channel k occupies slice k
alarm_en  in  N_ALARMS  per-channel arm switch; 0 = disarmed/dismiss
snooze  in  1  single-cycle pulse
min_tick  in  1  single-cycle pulse, once per clock minute
sec_tick  in  1  single-cycle pulse, once per second
z  out  1  buzzer enable
ringing  out  N_ALARMS  one-hot channel currently ringing or snoozed, else 0
snoozed  out  1  high in SNOOZED state
snooze_left  out  clog2(MAX_SNOOZE+1)  remaining snoozes for the current event

Behaviour:
- Clock is clk; reset is asynchronous and active-low. On reset: state IDLE, z=0, ringing=0, snoozed=0, snooze_left=MAX_SNOOZE, all counters 0, match history 0.
- match[k] = (all DIGITS digits equal) && alarm_en[k]. Registered each cycle as match_d[k].
- A trigger is the rising edge match[k] && !match_d[k]. A channel left matching for the whole minute triggers once only.
- FSM states: IDLE, RINGING, SNOOZED.
- IDLE -> RINGING on any trigger. Select the lowest-index triggering channel (ch). Set ringing=onehot(ch), snooze_left=MAX_SNOOZE, ring_cnt=0. z rises the cycle after the trigger cycle, giving 1-cycle latency.
- RINGING: z=1. On each min_tick, ring_cnt++. When ring_cnt reaches RING_MAX_MIN -> IDLE.
- RINGING -> SNOOZED on snooze when snooze_left>0. Then snooze_left--, snz_cnt=SNOOZE_MIN, z=0 next cycle. If snooze_left==0, snooze is ignored.
- SNOOZED: z=0. Each min_tick decrements snz_cnt. When it reaches 0 -> RINGING with ring_cnt=0.
- Dismiss: alarm_en[ch]==0 in RINGING or SNOOZED -> IDLE next cycle, with z=0 and ringing=0.
- Priority within one cycle: dismiss > timeout > snooze > min_tick count.
- Triggers on other channels while RINGING are ignored. A trigger while SNOOZED preempts: the FSM moves to RINGING on the new channel with snooze_left reloaded.
- A trigger in the same cycle as the IDLE return is honoured on the following cycle, provided the edge is still pending. Edge history is kept, so it is not lost.
- min_tick and sec_tick are ignored in IDLE. snooze pulses are ignored outside RINGING.
- Counter widths are clog2 of their maximum + 1. There is no wrap: counters saturate at their limits.
- Reset mid-ring returns to IDLE immediately (asynchronous), and z drops without waiting for a clock.

Optional Feature:
BEEP_PATTERN_EN. Defined: in RINGING, z toggles on every sec_tick, giving a 1 s on / 1 s off beep. z is forced to 1 on entry to RINGING and to 0 outside RINGING. Undefined: z is a steady 1 throughout RINGING. All other behaviour is identical either way.

Test Plan:
- Defaults. Set alarm0=07:30, alarm_en=01, then step time to 07:30 -> ringing=01, z=1 one cycle later. Hold the match for 3 min_ticks -> no retrigger. After 10 min_ticks -> IDLE, z=0.
- Snooze. While ringing, pulse snooze -> snoozed=1, z=0, snooze_left=2. After 5 min_ticks -> z=1. Snooze 3 more times -> the 4th snooze is ignored and z stays 1.
- Dismiss. Clear alarm_en[0] while SNOOZED -> IDLE next cycle, ringing=0. Assert snooze and dismiss in the same cycle -> dismiss wins.
- Simultaneous match. Set alarm0=alarm1=06:00 with both armed -> ringing=01 only. Alarm1 triggers while alarm0 is snoozed -> ringing=10, snooze_left=3.
- Reset. Assert reset mid-RINGING -> z=0 with no clock edge. After release -> IDLE; a time equal to the alarm that was already matching does not retrigger until a new edge.
- With BEEP_PATTERN_EN defined: in RINGING, 4 sec_ticks give z pattern 1,0,1,0,1 (initial value then one toggle per tick). Without it, z stays 1.
